seg_scan_reader: RTL and testbench
==================================

Name: seg_scan_reader

Overview:
- Inverse of the binary-to-seven-segment decoder: monitors a multiplexed seven-segment display bus and reconstructs the hexadecimal value being shown.
- Samples the segment lines and the digit selects, filters scan transitions, and decodes each stable glyph back to a nibble.
- Presents one assembled NUM_DIGITS-digit word per complete scan frame on a valid/ready interface.
- Used for display loopback self-test and for board-level checking of the decoder path.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- STABLE_CYCLES, 4, consecutive identical samples required before a glyph is accepted (>=2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- Seg  input  7  segment lines, active-high; Seg[6]=a, Seg[5]=b, ..., Seg[0]=g (same encoding the decoder drives)
- Digit_sel  input  NUM_DIGITS  one-hot digit enable, active-high; bit 0 = least-significant digit
- Value_out  output  4*NUM_DIGITS  assembled value; digit i occupies [4i+3:4i]
- Glyph_err  output  NUM_DIGITS  per-digit flag: captured pattern was not a legal hex glyph
- Out_valid  output  1  Value_out/Glyph_err hold a complete frame
- Out_ready  input  1  consumer accepts the frame
- Overrun  output  1  sticky: a frame was dropped because the output was still held

Behaviour:
- Reset (async assert, sync release): all registers 0; Value_out=0, Glyph_err=0, Out_valid=0, Overrun=0; synchroniser flops cleared.
- Input path: Seg and Digit_sel pass through a 2-flop synchroniser. All logic below uses the synchronised sample S={sel,seg}.
- Stability counter:
  - Increments when S equals the previous S and sel is exactly one-hot.
  - Resets to 1 when S changes. Held at 0 when sel is zero or multi-hot.
  - Saturates at STABLE_CYCLES. Width is $clog2(STABLE_CYCLES+1).
- Capture:
  - Occurs in the cycle the counter first reaches STABLE_CYCLES; at most once per dwell.
  - The selected digit's nibble register and err bit load from the glyph table. Its bit in a captured mask sets.
- Glyph table (abcdefg to nibble): 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9, 1110111=A, 0011111=b, 1001110=C, 0111101=d, 1001111=E, 1000111=F.
- Illegal glyph: any pattern outside the table gives nibble 0 with err=1.
- Recapture of a digit already in the mask overwrites that digit's nibble and err bit.
- Frame complete: the cycle the mask becomes all-ones.
  - If Out_valid=0 or (Out_valid and Out_ready) in that cycle: next cycle Value_out/Glyph_err load the working registers, Out_valid=1, mask clears.
  - Otherwise the frame is dropped, the mask clears, and Overrun is set. Overrun clears only on reset.
- Handshake:
  - Out_valid stays high and Value_out/Glyph_err stay stable until Out_valid and Out_ready in the same cycle.
  - Out_valid drops the following cycle unless a new frame loads in that same cycle (back-to-back).
- Latency: an input change reaches a capture after 2 (sync) + STABLE_CYCLES cycles. Out_valid rises 1 cycle after the final digit's capture.
- Glitch rejection: a scan edge where Seg and Digit_sel change on different cycles resets the counter. The transient pattern is never captured unless it persists STABLE_CYCLES.
- Mid-frame reset: everything clears, including a partial mask. The next frame starts from an empty mask.

Decomposition:
- Shared package seg7_pkg:
  - segment bit-index constants SEG_A..SEG_G;
  - the 16-entry glyph constant array;
  - function glyph_to_nibble returning {err, nibble}.
- The existing decoder uses the same package for the forward direction.
- One sub-module: seg_sync_filter (synchroniser, stability counter, capture strobe, one-hot check). Decode and frame assembly stay in the top level.

Test Plan:
- Scan digits 0..3 with glyphs for 1,2,3,4, each held 8 cycles, Out_ready=1 → one Out_valid pulse with Value_out=16'h4321, Glyph_err=4'b0000.
- Hold each digit only 3 cycles (STABLE_CYCLES=4) → no capture, Out_valid stays 0.
- Digit 2 shows 1010101 → Value_out nibble 2 = 0, Glyph_err=4'b0100, other digits decoded correctly.
- Out_ready=0 across two full frames (A,b,C,d then E,F,0,8) → Value_out holds 16'hdCbA, Overrun=1. After asserting Out_ready, Out_valid drops the next cycle.
- Skew Digit_sel one cycle ahead of Seg at each scan edge, plus a 2-cycle multi-hot sel → only steady glyphs are captured, value correct.
- Assert rst_n=0 after digits 0 and 1 are captured → all outputs 0. The next full frame of 5,6,7,8 yields 16'h8765 with no stale digits.

Source files
------------

// File: rtl/seg7_pkg.sv
// Seven-segment encoding shared by the forward decoder and the scan reader.
// Segment bit positions, the hex glyph table and the reverse lookup.
package seg7_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Indexed by nibble value; each entry is abcdefg
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Returns {err, nibble}; unknown patterns decode to 0 with err set
    function automatic logic [4:0] glyph_to_nibble(input logic [6:0] seg);
        logic [6:0] abcdefg;
        logic [4:0] result;
        abcdefg = {seg[SEG_A], seg[SEG_B], seg[SEG_C], seg[SEG_D],
                   seg[SEG_E], seg[SEG_F], seg[SEG_G]};
        result  = 5'b1_0000;
        for (int i = 0; i < 16; i++) begin
            if (abcdefg == GLYPH_TABLE[i]) begin
                result = {1'b0, 4'(i)};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seg_sync_filter.sv
// Synchronises the display bus and emits one capture strobe per stable dwell,
// together with the glyph and digit select that were held steady.
module seg_sync_filter #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg,
    input  logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  capture,
    output logic [6:0]            cap_seg,
    output logic [NUM_DIGITS-1:0] cap_sel
);

    localparam int SW = 7 + NUM_DIGITS;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [SW-1:0]         sync1, sync2, prev;
    logic [NUM_DIGITS-1:0] sel_s;
    logic [CW-1:0]         count, count_nx;
    logic                  one_hot;
    logic                  reach;

    always_comb begin
        sel_s   = sync2[SW-1:7];
        one_hot = (sel_s != '0) && ((sel_s & (sel_s - NUM_DIGITS'(1))) == '0);
        if (!one_hot) begin
            count_nx = '0;
        end else if (sync2 != prev) begin
            count_nx = CW'(1);
        end else if (count != CNT_MAX) begin
            count_nx = count + CW'(1);
        end else begin
            count_nx = count;
        end
        // Strobe only on the transition into saturation, so once per dwell
        reach = (count_nx == CNT_MAX) && (count != CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            prev    <= '0;
            count   <= '0;
            capture <= 1'b0;
            cap_seg <= '0;
            cap_sel <= '0;
        end else begin
            sync1   <= {digit_sel, seg};
            sync2   <= sync1;
            prev    <= sync2;
            count   <= count_nx;
            capture <= reach;
            if (reach) begin
                cap_seg <= sync2[6:0];
                cap_sel <= sel_s;
            end
        end
    end

endmodule

// File: rtl/seg_scan_reader.sv
// Reconstructs the hex value shown on a multiplexed seven-segment display
// and hands out one assembled word per complete scan frame.
module seg_scan_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              Seg,
    input  logic [NUM_DIGITS-1:0]   Digit_sel,
    output logic [4*NUM_DIGITS-1:0] Value_out,
    output logic [NUM_DIGITS-1:0]   Glyph_err,
    output logic                    Out_valid,
    input  logic                    Out_ready,
    output logic                    Overrun
);

    import seg7_pkg::*;

    localparam int VW = 4 * NUM_DIGITS;

    logic                  capture;
    logic [6:0]            cap_seg;
    logic [NUM_DIGITS-1:0] cap_sel;
    logic [4:0]            decoded;
    logic [VW-1:0]         work_val, work_val_nx;
    logic [NUM_DIGITS-1:0] work_err, work_err_nx;
    logic [NUM_DIGITS-1:0] mask, mask_nx;
    logic                  frame_done;
    logic                  accept;

    seg_sync_filter #(
        .NUM_DIGITS    (NUM_DIGITS),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg       (Seg),
        .digit_sel (Digit_sel),
        .capture   (capture),
        .cap_seg   (cap_seg),
        .cap_sel   (cap_sel)
    );

    // Merge the captured digit into the working frame; a recapture overwrites
    always_comb begin
        decoded     = glyph_to_nibble(cap_seg);
        work_val_nx = work_val;
        work_err_nx = work_err;
        mask_nx     = mask;
        if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cap_sel[i]) begin
                    work_val_nx[4*i +: 4] = decoded[3:0];
                    work_err_nx[i]        = decoded[4];
                end
            end
            mask_nx = mask | cap_sel;
        end
        frame_done = capture && (mask_nx == '1);
        accept     = !Out_valid || Out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_val  <= '0;
            work_err  <= '0;
            mask      <= '0;
            Value_out <= '0;
            Glyph_err <= '0;
            Out_valid <= 1'b0;
            Overrun   <= 1'b0;
        end else begin
            work_val <= work_val_nx;
            work_err <= work_err_nx;
            mask     <= frame_done ? '0 : mask_nx;
            if (frame_done && accept) begin
                Value_out <= work_val_nx;
                Glyph_err <= work_err_nx;
                Out_valid <= 1'b1;
            end else if (Out_valid && Out_ready) begin
                Out_valid <= 1'b0;
            end
            if (frame_done && !accept) begin
                Overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_reader.sv
// Directed bench for seg_scan_reader: frames are scanned onto the display bus
// and every handshaked output word is matched against a queue of expected words.
module tb_seg_scan_reader;

    localparam int NUM_DIGITS    = 4;
    localparam int STABLE_CYCLES = 4;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };
    localparam logic [6:0] BAD_GLYPH = 7'b1010101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  Seg = '0;
    logic [3:0]  Digit_sel = '0;
    logic [15:0] Value_out;
    logic [3:0]  Glyph_err;
    logic        Out_valid;
    logic        Out_ready = 1'b1;
    logic        Overrun;

    int checks = 0;
    int errors = 0;

    logic [19:0] exp_q [$];
    logic [19:0] obs_q [$];

    always #5 clk = ~clk;

    seg_scan_reader #(
        .NUM_DIGITS    (NUM_DIGITS),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Seg       (Seg),
        .Digit_sel (Digit_sel),
        .Value_out (Value_out),
        .Glyph_err (Glyph_err),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Overrun   (Overrun)
    );

    // Record every word the consumer takes
    always @(negedge clk) begin
        if (rst_n && Out_valid && Out_ready) begin
            obs_q.push_back({Glyph_err, Value_out});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input logic [6:0] glyph, input int hold);
        Digit_sel = 4'(1 << idx);
        Seg       = glyph;
        tick(hold);
    endtask

    task automatic idleBus(input int n);
        Digit_sel = '0;
        Seg       = '0;
        tick(n);
    endtask

    task automatic scanFrame(input logic [6:0] g0, input logic [6:0] g1,
                             input logic [6:0] g2, input logic [6:0] g3, input int hold);
        applyStimulus(0, g0, hold);
        applyStimulus(1, g1, hold);
        applyStimulus(2, g2, hold);
        applyStimulus(3, g3, hold);
        idleBus(6);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkScoreboard(input string tag);
        logic [19:0] o, e;
        checkOutput({tag, " word count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checkOutput({tag, " value"}, 32'(o[15:0]), 32'(e[15:0]));
            checkOutput({tag, " glyph_err"}, 32'(o[19:16]), 32'(e[19:16]));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(2);
        checkOutput("reset value", 32'(Value_out), 32'h0);
        checkOutput("reset err", 32'(Glyph_err), 32'h0);
        checkOutput("reset valid", 32'(Out_valid), 32'h0);
        checkOutput("reset overrun", 32'(Overrun), 32'h0);

        $display("[TB] basic frame");
        exp_q.push_back({4'b0000, 16'h4321});
        scanFrame(GLYPH[1], GLYPH[2], GLYPH[3], GLYPH[4], 8);
        checkScoreboard("basic");

        $display("[TB] short dwell");
        scanFrame(GLYPH[5], GLYPH[6], GLYPH[7], GLYPH[8], 3);
        checkScoreboard("short dwell");
        checkOutput("short dwell valid", 32'(Out_valid), 32'h0);

        $display("[TB] illegal glyph");
        exp_q.push_back({4'b0100, 16'h5097});
        scanFrame(GLYPH[7], GLYPH[9], BAD_GLYPH, GLYPH[5], 8);
        checkScoreboard("illegal");

        $display("[TB] backpressure");
        Out_ready = 1'b0;
        scanFrame(GLYPH[10], GLYPH[11], GLYPH[12], GLYPH[13], 8);
        scanFrame(GLYPH[14], GLYPH[15], GLYPH[0], GLYPH[8], 8);
        checkOutput("held valid", 32'(Out_valid), 32'h1);
        checkOutput("held value", 32'(Value_out), 32'hDCBA);
        checkOutput("held err", 32'(Glyph_err), 32'h0);
        checkOutput("overrun set", 32'(Overrun), 32'h1);
        checkScoreboard("held no take");
        exp_q.push_back({4'b0000, 16'hDCBA});
        Out_ready = 1'b1;
        tick(1);
        checkOutput("valid drop", 32'(Out_valid), 32'h0);
        checkScoreboard("release");
        checkOutput("overrun sticky", 32'(Overrun), 32'h1);

        $display("[TB] skewed scan");
        exp_q.push_back({4'b0000, 16'h2689});
        Digit_sel = 4'b0001; Seg = 7'b0000000;  tick(1);
        Seg = GLYPH[9];                          tick(7);
        Digit_sel = 4'b0010;                     tick(1);
        Seg = GLYPH[8];                          tick(7);
        Digit_sel = 4'b0110;                     tick(2);
        Digit_sel = 4'b0100;                     tick(1);
        Seg = GLYPH[6];                          tick(7);
        Digit_sel = 4'b1000;                     tick(1);
        Seg = GLYPH[2];                          tick(7);
        idleBus(6);
        checkScoreboard("skew");

        $display("[TB] mid-frame reset");
        applyStimulus(0, GLYPH[5], 8);
        applyStimulus(1, GLYPH[6], 8);
        idleBus(2);
        rst_n = 1'b0;
        tick(1);
        checkOutput("mid reset value", 32'(Value_out), 32'h0);
        checkOutput("mid reset err", 32'(Glyph_err), 32'h0);
        checkOutput("mid reset valid", 32'(Out_valid), 32'h0);
        checkOutput("mid reset overrun", 32'(Overrun), 32'h0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        applyStimulus(2, GLYPH[7], 8);
        applyStimulus(3, GLYPH[8], 8);
        idleBus(6);
        checkScoreboard("no stale digits");
        checkOutput("partial valid", 32'(Out_valid), 32'h0);
        exp_q.push_back({4'b0000, 16'h8765});
        applyStimulus(0, GLYPH[5], 8);
        applyStimulus(1, GLYPH[6], 8);
        idleBus(6);
        checkScoreboard("after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
